// File: rtl/task_mem_reader.sv
// Task-memory reader: walks the packed task bus and streams each task's instructions over valid/ready.
// Optional macro TM_READER_LOOP_EN: restart at task 0 instead of finishing a pass.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | out of reset, waiting for start
// CHECK  | testing word 0 of task_idx for an empty task
// STREAM | presenting word (task_idx, insn_idx) to the consumer
// DONE   | pass finished, waiting for a new start
module task_mem_reader #(
  parameter int TASK_MEM_DEPTH = 16,
  parameter int INSN_COUNT     = 16,
  parameter int INSN_SIZE      = 16,
  parameter int TASK_MEM_WIDTH = INSN_COUNT * INSN_SIZE,
  localparam int TIW = (TASK_MEM_DEPTH > 1) ? $clog2(TASK_MEM_DEPTH) : 1,
  localparam int IIW = (INSN_COUNT > 1) ? $clog2(INSN_COUNT) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  input  logic [TASK_MEM_DEPTH*TASK_MEM_WIDTH-1:0] task_memory,
  output logic [INSN_SIZE-1:0]                     insn_out,
  output logic                                     insn_valid,
  input  logic                                     insn_ready,
  output logic                                     insn_last,
  output logic [TIW-1:0]                           task_idx,
  output logic [IIW-1:0]                           insn_idx,
  output logic                                     busy,
  output logic                                     done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [INSN_SIZE-1:0] STOP_WORD = INSN_SIZE'(16'hf000);
  localparam logic [TIW-1:0]       LAST_TASK = TIW'(TASK_MEM_DEPTH - 1);
  localparam logic [IIW-1:0]       LAST_SLOT = IIW'(INSN_COUNT - 1);

  logic [1:0]           state;
  logic [INSN_SIZE-1:0] words [TASK_MEM_DEPTH][INSN_COUNT];
  logic [INSN_SIZE-1:0] cur_word;
  logic                 cur_last;
  logic                 xfer;

  for (genvar i = 0; i < TASK_MEM_DEPTH; i++) begin : g_task
    for (genvar k = 0; k < INSN_COUNT; k++) begin : g_slot
      assign words[i][k] = task_memory[k*INSN_SIZE + i*TASK_MEM_WIDTH +: INSN_SIZE];
    end
  end

  assign cur_word   = words[task_idx][insn_idx];
  assign cur_last   = (cur_word == STOP_WORD) || (insn_idx == LAST_SLOT);
  assign insn_valid = (state == STREAM);
  assign insn_out   = insn_valid ? cur_word : '0;
  assign insn_last  = insn_valid && cur_last;
  assign busy       = (state == CHECK) || (state == STREAM);
  assign xfer       = insn_valid && insn_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      task_idx <= '0;
      insn_idx <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= CHECK;
            task_idx <= '0;
            insn_idx <= '0;
            done     <= 1'b0;
          end
        end
        CHECK: begin
          if (words[task_idx][0] == '0) begin
`ifdef TM_READER_LOOP_EN
            // An empty task 0 would restart forever, so park in DONE instead.
            if (task_idx == '0) begin
              state <= DONE;
            end else begin
              state    <= CHECK;
              task_idx <= '0;
            end
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            state    <= STREAM;
            insn_idx <= '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (cur_last) begin
              insn_idx <= '0;
              if (task_idx == LAST_TASK) begin
`ifdef TM_READER_LOOP_EN
                state    <= CHECK;
                task_idx <= '0;
`else
                state <= DONE;
                done  <= 1'b1;
`endif
              end else begin
                state    <= CHECK;
                task_idx <= task_idx + TIW'(1);
              end
            end else begin
              insn_idx <= insn_idx + IIW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_mem_reader.sv
// Randomized and directed bench for task_mem_reader against a list-of-beats reference model.
`timescale 1ns/1ps

module tb_task_mem_reader;
  localparam int DEPTH = 16;
  localparam int COUNT = 16;
  localparam int ISZ   = 16;
  localparam int TMW   = COUNT * ISZ;

  logic                   clk;
  logic                   reset_n;
  logic                   start;
  logic [DEPTH*TMW-1:0]   task_memory;
  logic [ISZ-1:0]         insn_out;
  logic                   insn_valid;
  logic                   insn_ready;
  logic                   insn_last;
  logic [3:0]             task_idx;
  logic [3:0]             insn_idx;
  logic                   busy;
  logic                   done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          t;
    int          k;
    logic [15:0] w;
    logic        l;
  } beat_t;

  beat_t exp_q[$];

  task_mem_reader #(.TASK_MEM_DEPTH(DEPTH), .INSN_COUNT(COUNT), .INSN_SIZE(ISZ)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .task_memory(task_memory),
    .insn_out(insn_out), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn_last(insn_last), .task_idx(task_idx), .insn_idx(insn_idx),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] wd(input int t, input int k);
    return task_memory[t*TMW + k*ISZ +: ISZ];
  endfunction

  task automatic set_wd(input int t, input int k, input logic [15:0] v);
    task_memory[t*TMW + k*ISZ +: ISZ] = v;
  endtask

  // Expected beats of one pass, straight from the program rules.
  function automatic void build_model();
    beat_t b;
    exp_q.delete();
    for (int t = 0; t < DEPTH; t++) begin
      if (wd(t, 0) == 16'h0) break;
      for (int k = 0; k < COUNT; k++) begin
        b.t = t; b.k = k; b.w = wd(t, k);
        b.l = (b.w == 16'hf000) || (k == COUNT - 1);
        exp_q.push_back(b);
        if (b.l) break;
      end
    end
  endfunction

  task automatic rand_program(input int empty_at);
    logic [15:0] w;
    int          s;
    task_memory = '0;
    for (int t = 0; t < DEPTH; t++) begin
      if (t == empty_at) continue;
      for (int k = 0; k < COUNT; k++) begin
        w = 16'($urandom);
        if (k > 0 && $urandom_range(0, 5) == 0) w = 16'h0;
        if (w == 16'hf000) w = 16'hf001;
        if (k == 0 && w == 16'h0) w = 16'h0001;
        set_wd(t, k, w);
      end
      if ($urandom_range(0, 3) != 0) begin
        s = $urandom_range(0, COUNT - 1);
        set_wd(t, s, 16'hf000);
      end
    end
  endtask

  function automatic logic pick_ready(input int mode, input logic cur);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ~cur;
    return ($urandom_range(0, 2) != 0);
  endfunction

  // One full pass; mode 0 ready high, 1 toggling ready, 2 random ready plus start noise while busy.
  task automatic run_pass(input int mode, input string name);
    beat_t       b;
    int          cyc, last_xfer, first_valid, gap_exp, n_exp;
    logic        stalled;
    logic [15:0] p_out;
    logic        p_last;
    logic [3:0]  p_tidx, p_iidx;
    build_model();
    n_exp   = exp_q.size();
    gap_exp = (n_exp == 0) ? 1 : ((exp_q[$].t == DEPTH - 1) ? 1 : 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_check_busy"}, busy, 1);
    chk({name, "_check_novalid"}, insn_valid, 0);
    chk({name, "_done_cleared"}, done, 0);
    cyc = 0; last_xfer = 0; first_valid = -1; stalled = 1'b0;
    p_out = '0; p_last = 1'b0; p_tidx = '0; p_iidx = '0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      insn_ready = pick_ready(mode, insn_ready);
      if (insn_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          chk({name, "_stall_out"}, insn_out, p_out);
          chk({name, "_stall_last"}, insn_last, p_last);
          chk({name, "_stall_idx"}, {task_idx, insn_idx}, {p_tidx, p_iidx});
        end
        if (insn_ready) begin
          if (exp_q.size() == 0) begin
            chk({name, "_extra_beat"}, 1, 0);
          end else begin
            b = exp_q.pop_front();
            chk({name, "_beat_word"}, insn_out, b.w);
            chk({name, "_beat_last"}, insn_last, b.l);
            chk({name, "_beat_task"}, task_idx, b.t);
            chk({name, "_beat_slot"}, insn_idx, b.k);
          end
          last_xfer = cyc;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          p_out = insn_out; p_last = insn_last; p_tidx = task_idx; p_iidx = insn_idx;
        end
      end else begin
        stalled = 1'b0;
        chk({name, "_idle_out_zero"}, {insn_out, 15'h0, insn_last}, 0);
      end
      start = (mode == 2 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_beats_left"}, exp_q.size(), 0);
    if (n_exp > 0) begin
      chk({name, "_first_beat_latency"}, first_valid, 1);
      chk({name, "_done_gap"}, cyc - last_xfer, gap_exp);
    end else begin
      chk({name, "_empty_done_latency"}, cyc, gap_exp);
    end
    chk({name, "_end_busy"}, busy, 0);
    chk({name, "_end_valid"}, insn_valid, 0);
  endtask

  initial begin
    int waited;
    reset_n = 1'b0; start = 1'b0; insn_ready = 1'b0; task_memory = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {insn_out, insn_valid, insn_last, task_idx, insn_idx, busy, done}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_busy", busy, 0);

`ifdef TM_READER_LOOP_EN
    rand_program(2);
    for (int k = 0; k < COUNT; k++) begin
      set_wd(0, k, (k == 3) ? 16'hf000 : 16'(k + 16'h100));
      set_wd(1, k, (k == 1) ? 16'hf000 : 16'(k + 16'h200));
    end
    build_model();
    insn_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int pos;
      pos = 0;
      for (int c = 0; c < 300 && pos < 3 * exp_q.size(); c++) begin
        @(posedge clk); #1;
        chk("loop_done_low", done, 0);
        if (insn_valid) begin
          chk("loop_beat_word", insn_out, exp_q[pos % exp_q.size()].w);
          chk("loop_beat_task", task_idx, exp_q[pos % exp_q.size()].t);
          chk("loop_beat_last", insn_last, exp_q[pos % exp_q.size()].l);
          pos++;
        end
      end
      chk("loop_three_passes", pos >= 3 * exp_q.size(), 1);
      chk("loop_still_busy", busy, 1);
    end
`else
    task_memory = '0;
    set_wd(0, 0, 16'h0002);
    set_wd(0, 1, 16'hffff);
    run_pass(0, "full_task");

    task_memory = '0;
    begin
      logic [15:0] prog [8];
      prog = '{16'hc008, 16'hc041, 16'h3182, 16'h1123, 16'hc014, 16'hc407, 16'hc006, 16'hf000};
      for (int k = 0; k < 8; k++) set_wd(0, k, prog[k]);
    end
    run_pass(0, "stop_prog");
    run_pass(1, "stop_prog_toggle");

    task_memory = '0;
    for (int t = 0; t < DEPTH; t++) set_wd(t, 0, 16'hf000);
    run_pass(2, "all_single");

    task_memory = '0;
    run_pass(0, "empty_first");

    rand_program(DEPTH);
    for (int t = 0; t < DEPTH; t++)
      for (int k = 0; k < COUNT; k++)
        if (wd(t, k) == 16'hf000) set_wd(t, k, 16'hf00f);
    insn_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!(insn_valid && task_idx == 4'd2) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reach_task2", insn_valid && task_idx == 4'd2, 1);
    reset_n = 1'b0;
    #1;
    chk("midpass_reset", {insn_out, insn_valid, insn_last, task_idx, insn_idx, busy, done}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_pass(0, "after_reset");

    for (int r = 0; r < 6; r++) begin
      rand_program($urandom_range(1, DEPTH));
      run_pass(2, "random");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
